iob_modcnt_seq: RTL and testbench
=================================

Name: iob_modcnt_seq

Overview:
- Run sequencer for a modulo counter datapath.
- On start, latches a configuration (modulus, initial value, number of periods), loads the counter, and advances it modulo mod.
- Counts completed periods (wraps) and stops itself after the programmed count.
- Sits between a CSR/software interface and timing logic (PWM, baud/tick generators) that needs bounded, restartable modulo sequences with pause/stop control.

Parameters:
DATA_W, 32, width of counter, modulus and load value
PER_W, 16, width of period count and period counter

Ports:
clk  input  1  system clock, all state on rising edge
arst_n  input  1  asynchronous reset, active-low
rst  input  1  synchronous clear, active-high, same effect as arst_n
start  input  1  run request pulse; accepted only in IDLE or DONE
stop  input  1  abort request; effective in LOAD or RUN
pause  input  1  level; freezes counter in RUN
mod_i  input  DATA_W  modulus, latched on accepted start
load_val_i  input  DATA_W  initial counter value, latched on accepted start
nper_i  input  PER_W  periods to run, latched on accepted start
cnt  output  DATA_W  counter value
per_cnt  output  PER_W  completed periods in current/last run
wrap  output  1  one-cycle pulse, high in the cycle cnt shows 0 after a wrap
busy  output  1  high in LOAD and RUN
done  output  1  high in DONE
err  output  1  high in DONE when the run was rejected for bad config

Behaviour:
- Reset (arst_n low or rst high): state IDLE, cnt all ones, per_cnt 0, wrap/busy/done/err 0. rst has priority over all other inputs.
- States: IDLE, LOAD, RUN, DONE. busy = (LOAD|RUN); done = DONE.
- IDLE/DONE + start:
  - Latch mod_i, load_val_i, nper_i; clear per_cnt, err.
  - If mod_i==0 or nper_i==0: go to DONE with err=1; cnt unchanged.
  - Else go to LOAD.
- start while LOAD/RUN: ignored; latched config unchanged.
- LOAD (exactly 1 cycle):
  - cnt <= load_val, or 0 if load_val >= mod.
  - Go to RUN. pause has no effect in LOAD.
  - Latency: start sampled at edge T -> busy=1 after T; cnt=load_val after T+1.
- RUN, per edge, priority order:
  - stop: go to IDLE; cnt and per_cnt hold; no wrap, done stays 0.
  - pause: hold everything.
  - cnt == mod-1: cnt <= 0, wrap <= 1, per_cnt <= per_cnt+1. If per_cnt+1 == nper, go to DONE at the same edge.
  - Else: cnt <= cnt+1.
- wrap is registered: high exactly one cycle, coincident with cnt==0 after a wrap; 0 in every other cycle, including LOAD when load_val>=mod forces 0.
- mod==1: cnt stays 0; wrap high every non-paused RUN cycle; per_cnt increments each cycle.
- Arithmetic: mod-1 and cnt+1 computed in DATA_W bits; per_cnt in PER_W bits, no saturation needed since it stops at nper.
- DONE: cnt holds 0 (or unchanged if err); per_cnt holds nper; outputs held until next start or reset. A start in DONE restarts directly (DONE -> LOAD).
- stop in IDLE/DONE: ignored. Simultaneous start+stop in IDLE: start accepted, stop ignored.
- Reset mid-run: immediate return to reset values; no done or wrap is generated.

Test Plan:
- Reset then idle 5 cycles -> cnt=all ones, per_cnt=0, busy/done/wrap/err=0.
- start with mod=4, load_val=2, nper=3 -> busy next cycle; cnt sequence 2,3,0(wrap),1,2,3,0(wrap),1,2,3,0(wrap) -> done=1, busy=0, per_cnt=3, cnt=0; 3 wrap pulses total.
- Same run with pause held 3 cycles while cnt=1 -> cnt holds 1 for 3 cycles, no wrap; final sequence otherwise identical, completion 3 cycles later.
- mod=5, load_val=0, nper=10, stop asserted at cnt=3 in first period -> IDLE next cycle, cnt=3, per_cnt=0, done=0; a later start restarts from load_val.
- start with mod=0 or nper=0 -> done=1, err=1 next cycle, busy never 1; then start with mod=2, nper=1 -> err clears and the run completes after 2 RUN cycles.
- load_val=7 with mod=4 -> cnt=0 after LOAD, no wrap. Also: mod=1, nper=4 -> wrap high 4 consecutive cycles, then done. Also: arst_n low mid-RUN -> all outputs back to reset values asynchronously.

Source files
------------

// File: rtl/iob_modcnt_seq.sv
// iob_modcnt_seq: run sequencer for a modulo counter.
// Latches config on start, counts modulo mod, stops after nper wraps.
module iob_modcnt_seq #(
  parameter int DATA_W = 32,
  parameter int PER_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [DATA_W-1:0] mod_i,
  input  logic [DATA_W-1:0] load_val_i,
  input  logic [PER_W-1:0]  nper_i,
  output logic [DATA_W-1:0] cnt,
  output logic [PER_W-1:0]  per_cnt,
  output logic              wrap,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_mod;
  logic [DATA_W-1:0] r_load;
  logic [PER_W-1:0]  r_nper;

  logic [DATA_W-1:0] r_cnt;
  logic [PER_W-1:0]  r_per;
  logic              r_wrap;
  logic              r_err;

  logic [DATA_W-1:0] w_cnt_nxt;
  logic [PER_W-1:0]  w_per_nxt;
  logic              w_wrap_nxt;
  logic              w_err_nxt;
  logic              w_cfg_we;

  logic              w_idle_like;
  logic              w_accept;
  logic              w_bad_cfg;
  logic [DATA_W-1:0] w_mod_m1;
  logic [DATA_W-1:0] w_cnt_inc;
  logic [PER_W-1:0]  w_per_inc;
  logic              w_at_top;
  logic              w_last;
  logic [DATA_W-1:0] w_load_cnt;

  assign w_idle_like = (r_state == S_IDLE)
                     | (r_state == S_DONE);
  assign w_accept    = start & w_idle_like;
  assign w_bad_cfg   = (mod_i == '0)
                     | (nper_i == '0);

  assign w_mod_m1   = r_mod - 1'b1;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_per_inc  = r_per + 1'b1;
  assign w_at_top   = (r_cnt == w_mod_m1);
  assign w_last     = (w_per_inc == r_nper);
  // An out-of-range load value would never
  // hit mod-1, so it is folded to zero.
  assign w_load_cnt = (r_load >= r_mod)
                    ? '0 : r_load;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next datapath values
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_per_nxt   = r_per;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_cfg_we    = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_cfg_we  = 1'b1;
          w_per_nxt = '0;
          w_err_nxt = w_bad_cfg;
          w_state_nxt = w_bad_cfg
                      ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = w_load_cnt;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (pause) begin
          w_state_nxt = S_RUN;
        end else if (w_at_top) begin
          w_cnt_nxt  = '0;
          w_wrap_nxt = 1'b1;
          w_per_nxt  = w_per_inc;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Configuration latched on an accepted start
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mod  <= '0;
      r_load <= '0;
      r_nper <= '0;
    end else if (rst) begin
      r_mod  <= '0;
      r_load <= '0;
      r_nper <= '0;
    end else if (w_cfg_we) begin
      r_mod  <= mod_i;
      r_load <= load_val_i;
      r_nper <= nper_i;
    end
  end

  // Counter, period count, wrap pulse, error flag
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt  <= '1;
      r_per  <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else if (rst) begin
      r_cnt  <= '1;
      r_per  <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_per  <= w_per_nxt;
      r_wrap <= w_wrap_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign cnt     = r_cnt;
  assign per_cnt = r_per;
  assign wrap    = r_wrap;
  assign busy    = (r_state == S_LOAD)
                 | (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign err     = r_err;

  a_busy_done_excl: assert property (
    @(posedge clk) disable iff (!arst_n || rst)
    !(busy && done));

  a_wrap_at_zero: assert property (
    @(posedge clk) disable iff (!arst_n || rst)
    wrap |-> (cnt == '0));

  a_per_bounded: assert property (
    @(posedge clk) disable iff (!arst_n || rst)
    (r_state == S_RUN) |-> (r_per < r_nper));

endmodule

// File: tb/tb_iob_modcnt_seq.sv
// tb_iob_modcnt_seq: random and directed runs
// against a modulo-arithmetic reference model.
module tb_iob_modcnt_seq;

  localparam int DW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic [DW-1:0] mod_i = '0;
  logic [DW-1:0] load_val_i = '0;
  logic [PW-1:0] nper_i = '0;
  logic [DW-1:0] cnt;
  logic [PW-1:0] per_cnt;
  logic          wrap;
  logic          busy;
  logic          done;
  logic          err;

  iob_modcnt_seq #(.DATA_W(DW), .PER_W(PW)) dut (
    .clk(clk), .arst_n(arst_n), .rst(rst),
    .start(start), .stop(stop), .pause(pause),
    .mod_i(mod_i), .load_val_i(load_val_i),
    .nper_i(nper_i), .cnt(cnt), .per_cnt(per_cnt),
    .wrap(wrap), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: phase 0 idle, 1 load, 2 run, 3 done
  int            m_ph;
  logic [DW-1:0] m_cnt, m_mod, m_lv;
  logic [PW-1:0] m_per, m_np;
  bit            m_wrap, m_err;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = 0; m_cnt = '1; m_per = '0;
    m_wrap = 0; m_err = 0;
  endtask

  task automatic m_step(input bit st, sp, pa, rs,
                        input logic [DW-1:0] md, lv,
                        input logic [PW-1:0] np);
    logic [63:0] t;
    m_wrap = 0;
    if (rs) begin
      m_reset();
    end else if (m_ph == 0 || m_ph == 3) begin
      if (st) begin
        m_mod = md; m_lv = lv; m_np = np;
        m_per = '0;
        if (md == 0 || np == 0) begin
          m_err = 1; m_ph = 3;
        end else begin
          m_err = 0; m_ph = 1;
        end
      end
    end else if (m_ph == 1) begin
      if (sp) m_ph = 0;
      else begin
        m_cnt = (m_lv < m_mod) ? m_lv : '0;
        m_ph = 2;
      end
    end else begin
      if (sp) m_ph = 0;
      else if (!pa) begin
        t = ({32'd0, m_cnt} + 64'd1)
          % {32'd0, m_mod};
        m_cnt = t[DW-1:0];
        if (m_cnt == 0) begin
          m_wrap = 1;
          m_per = m_per + 1'b1;
          if (m_per == m_np) m_ph = 3;
        end
      end
    end
  endtask

  task automatic cmp_all(input string p);
    chk({p, ".cnt"}, 64'(cnt), 64'(m_cnt));
    chk({p, ".per"}, 64'(per_cnt), 64'(m_per));
    chk({p, ".wrap"}, 64'(wrap), 64'(m_wrap));
    chk({p, ".busy"}, 64'(busy),
        64'(m_ph == 1 || m_ph == 2));
    chk({p, ".done"}, 64'(done), 64'(m_ph == 3));
    chk({p, ".err"}, 64'(err), 64'(m_err));
  endtask

  int nwrap;

  task automatic cyc(input string p,
                     input bit st, sp, pa, rs,
                     input logic [DW-1:0] md, lv,
                     input logic [PW-1:0] np);
    start = st; stop = sp; pause = pa; rst = rs;
    mod_i = md; load_val_i = lv; nper_i = np;
    @(posedge clk);
    m_step(st, sp, pa, rs, md, lv, np);
    #1;
    if (wrap) nwrap++;
    cmp_all(p);
    start = 0; stop = 0; pause = 0; rst = 0;
  endtask

  task automatic idle(input string p);
    cyc(p, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic run_done(input string p,
                          input int budget);
    int n = 0;
    while (m_ph != 3 && n < budget) begin
      idle(p); n++;
    end
    chk({p, ".reached"}, 64'(m_ph == 3), 64'd1);
  endtask

  initial begin
    m_reset();
    m_mod = '0; m_lv = '0; m_np = '0;
    @(negedge clk);
    #1;
    cmp_all("arst");
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle("rst_idle");

    // basic run 4/2/3
    nwrap = 0;
    cyc("basic", 1, 0, 0, 0, 4, 2, 3);
    run_done("basic", 30);
    chk("basic.nwrap", 64'(nwrap), 64'd3);
    chk("basic.cntf", 64'(cnt), 64'd0);
    chk("basic.perf", 64'(per_cnt), 64'd3);

    // same run, pause 3 cycles at cnt=1
    nwrap = 0;
    cyc("pause", 1, 0, 0, 0, 4, 2, 3);
    for (int n = 0; n < 10; n++)
      if (!(m_ph == 2 && m_cnt == 1)) idle("pause");
    for (int i = 0; i < 3; i++)
      cyc("pause.h", 0, 0, 1, 0, '0, '0, '0);
    chk("pause.hold", 64'(cnt), 64'd1);
    run_done("pause", 30);
    chk("pause.nwrap", 64'(nwrap), 64'd3);

    // stop at cnt=3
    cyc("stop", 1, 0, 0, 0, 5, 0, 10);
    for (int n = 0; n < 10; n++)
      if (!(m_ph == 2 && m_cnt == 3)) idle("stop");
    cyc("stop.s", 0, 1, 0, 0, '0, '0, '0);
    chk("stop.cnt", 64'(cnt), 64'd3);
    chk("stop.busy", 64'(busy), 64'd0);
    idle("stop.i");
    cyc("stop.rs", 1, 0, 0, 0, 5, 0, 2);
    idle("stop.rs");
    chk("stop.reload", 64'(cnt), 64'd0);
    run_done("stop.rs", 30);

    // bad configs, then good
    cyc("bad0", 1, 0, 0, 0, 0, 1, 3);
    chk("bad0.err", 64'(err), 64'd1);
    cyc("bad1", 1, 0, 0, 0, 3, 1, 0);
    cyc("good", 1, 0, 0, 0, 2, 0, 1);
    chk("good.err", 64'(err), 64'd0);
    run_done("good", 10);

    // load >= mod, and mod=1
    nwrap = 0;
    cyc("ovl", 1, 0, 0, 0, 4, 7, 1);
    idle("ovl");
    chk("ovl.cnt", 64'(cnt), 64'd0);
    run_done("ovl", 20);
    nwrap = 0;
    cyc("m1", 1, 1, 0, 0, 1, 0, 4);
    run_done("m1", 20);
    chk("m1.nwrap", 64'(nwrap), 64'd4);

    // sync reset mid-run
    cyc("srst", 1, 0, 0, 0, 6, 1, 3);
    idle("srst"); idle("srst");
    cyc("srst.r", 1, 1, 0, 1, 6, 1, 3);

    // async reset mid-run
    cyc("arst", 1, 0, 0, 0, 6, 1, 3);
    idle("arst"); idle("arst");
    #2 arst_n = 1'b0;
    #1 m_reset();
    cmp_all("arst.mid");
    @(negedge clk);
    arst_n = 1'b1;
    idle("arst.after");

    // random
    for (int i = 0; i < 4000; i++) begin
      cyc("rnd",
          ($urandom % 6) == 0,
          ($urandom % 25) == 0,
          ($urandom % 5) == 0,
          ($urandom % 300) == 0,
          DW'($urandom_range(0, 6)),
          DW'($urandom_range(0, 8)),
          PW'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
